// File: rtl/hash_axil_pkg.sv
// Shared definitions for the FNV-1a AXI4-Lite hash peripheral: register offsets,
// FNV constants, AXI response codes and the byte-engine state encoding.
package hash_axil_pkg;

    localparam logic [31:0] REG_CTRL      = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS    = 32'h0000_0004;
    localparam logic [31:0] REG_DATA_IN   = 32'h0000_0008;
    localparam logic [31:0] REG_HASH      = 32'h0000_000C;
    localparam logic [31:0] REG_USER_BASE = 32'h0000_0010;

    localparam logic [31:0] FNV_SEED  = 32'h811C_9DC5;
    localparam logic [31:0] FNV_PRIME = 32'h0100_0193;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        ENG_IDLE = 1'b0,
        ENG_RUN  = 1'b1
    } eng_state_e;

    function automatic logic [31:0] fnv1a_step(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'h00_0000, b}) * FNV_PRIME;
    endfunction

endpackage

// File: rtl/fnv1a_byte_engine.sv
// FNV-1a 32-bit engine consuming one strobed byte lane per cycle, lowest lane first.
// done is a one-cycle pulse on the edge that commits the final byte.
module fnv1a_byte_engine
    import hash_axil_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_seed,
    input  logic        start,
    input  logic [3:0]  lane_mask,
    input  logic [31:0] word,
    output logic [31:0] hash,
    output logic        busy,
    output logic        done
);

    eng_state_e  state_r;
    logic [3:0]  mask_r;
    logic [31:0] word_r;
    logic [31:0] hash_r;

    logic [1:0]  lane_s;
    logic [7:0]  byte_s;
    logic [3:0]  mask_next_s;
    logic [31:0] hash_next_s;

    // Select the lowest pending lane and compute the next digest
    always_comb begin
        if (mask_r[0]) begin
            lane_s = 2'd0;
        end else if (mask_r[1]) begin
            lane_s = 2'd1;
        end else if (mask_r[2]) begin
            lane_s = 2'd2;
        end else begin
            lane_s = 2'd3;
        end
        case (lane_s)
            2'd0:    byte_s = word_r[7:0];
            2'd1:    byte_s = word_r[15:8];
            2'd2:    byte_s = word_r[23:16];
            2'd3:    byte_s = word_r[31:24];
            default: byte_s = word_r[7:0];
        endcase
        mask_next_s = mask_r & ~(4'b0001 << lane_s);
        hash_next_s = fnv1a_step(hash_r, byte_s);
    end

    // Engine state, pending lanes and running digest; seed load aborts any run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ENG_IDLE;
            mask_r  <= 4'h0;
            word_r  <= 32'h0000_0000;
            hash_r  <= FNV_SEED;
        end else if (load_seed) begin
            state_r <= ENG_IDLE;
            mask_r  <= 4'h0;
            hash_r  <= FNV_SEED;
        end else begin
            case (state_r)
                ENG_IDLE: begin
                    if (start && (lane_mask != 4'h0)) begin
                        state_r <= ENG_RUN;
                        mask_r  <= lane_mask;
                        word_r  <= word;
                    end
                end
                ENG_RUN: begin
                    hash_r <= hash_next_s;
                    mask_r <= mask_next_s;
                    if (mask_next_s == 4'h0) begin
                        state_r <= ENG_IDLE;
                    end
                end
                default: state_r <= ENG_IDLE;
            endcase
        end
    end

    assign hash = hash_r;
    assign busy = (state_r == ENG_RUN);
    assign done = (state_r == ENG_RUN) && (mask_next_s == 4'h0) && !load_seed;

endmodule

// File: rtl/hash_axil_fnv.sv
// AXI4-Lite register bank around an FNV-1a byte engine plus scratch registers.
// Define HASH_IRQ_EN to add the irq output and the CTRL.IRQ_EN bit.
module hash_axil_fnv
    import hash_axil_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_USER_REGS      = 4
) (
`ifdef HASH_IRQ_EN
    output logic                          irq,
`endif
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic        awready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]  bresp_r;
    logic [31:0] rdata_r;
    logic        done_r, overrun_r;
    logic [31:0] scratch_r [NUM_USER_REGS];

    logic [31:0] aw_off_s, ar_off_s, rd_data_s;
    logic        wr_fire_s, rd_fire_s;
    logic [1:0]  wr_resp_s;
    logic        init_s, ctrl_we_s, eng_start_s, overrun_set_s;
    logic [1:0]  w1c_s;
    logic [NUM_USER_REGS-1:0] user_wsel_s, user_rsel_s, user_we_s;
    logic        irq_en_rd_s;
    logic [31:0] eng_hash_s;
    logic        eng_busy_s, eng_done_s;
    logic        unused_s;

    assign aw_off_s  = 32'({S_AXI_AWADDR[AW-1:2], 2'b00});
    assign ar_off_s  = 32'({S_AXI_ARADDR[AW-1:2], 2'b00});
    assign wr_fire_s = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire_s = arready_r & S_AXI_ARVALID;
    assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], ctrl_we_s};

    // Scratch register hit decode for both channels
    always_comb begin
        user_wsel_s = {NUM_USER_REGS{1'b0}};
        user_rsel_s = {NUM_USER_REGS{1'b0}};
        for (int k = 0; k < NUM_USER_REGS; k++) begin
            user_wsel_s[k] = (aw_off_s == REG_USER_BASE + 32'(k) * 32'd4);
            user_rsel_s[k] = (ar_off_s == REG_USER_BASE + 32'(k) * 32'd4);
        end
    end

    // Write decode: side effects and response for the accepted write
    always_comb begin
        wr_resp_s     = RESP_OKAY;
        init_s        = 1'b0;
        ctrl_we_s     = 1'b0;
        w1c_s         = 2'b00;
        eng_start_s   = 1'b0;
        overrun_set_s = 1'b0;
        user_we_s     = {NUM_USER_REGS{1'b0}};
        if (wr_fire_s) begin
            case (aw_off_s)
                REG_CTRL: begin
                    ctrl_we_s = S_AXI_WSTRB[0];
                    init_s    = S_AXI_WSTRB[0] & S_AXI_WDATA[0];
                end
                REG_STATUS: begin
                    w1c_s = S_AXI_WDATA[2:1] & {2{S_AXI_WSTRB[0]}};
                end
                REG_DATA_IN: begin
                    if (S_AXI_WSTRB == 4'h0) begin
                        wr_resp_s = RESP_OKAY;
                    end else if (eng_busy_s) begin
                        wr_resp_s     = RESP_SLVERR;
                        overrun_set_s = 1'b1;
                    end else begin
                        eng_start_s = 1'b1;
                    end
                end
                default: begin
                    if (|user_wsel_s) begin
                        user_we_s = user_wsel_s;
                    end else begin
                        wr_resp_s = RESP_SLVERR;
                    end
                end
            endcase
        end else begin
            wr_resp_s = RESP_OKAY;
        end
    end

    // Write address/data handshake and single outstanding response
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            awready_r <= !awready_r && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r;
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_resp_s;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Sticky status bits and byte-strobed scratch registers; completion beats W1C
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                scratch_r[k] <= 32'h0000_0000;
            end
        end else begin
            if (eng_done_s) begin
                done_r <= 1'b1;
            end else if (init_s || w1c_s[0]) begin
                done_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (init_s || w1c_s[1]) begin
                overrun_r <= 1'b0;
            end
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (user_we_s[k] && S_AXI_WSTRB[b]) begin
                        scratch_r[k][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef HASH_IRQ_EN
    logic irq_en_r, irq_r;

    // Interrupt enable bit and registered completion interrupt
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (ctrl_we_s) begin
                irq_en_r <= S_AXI_WDATA[1];
            end
            irq_r <= done_r & irq_en_r;
        end
    end

    assign irq         = irq_r;
    assign irq_en_rd_s = irq_en_r;
`else
    assign irq_en_rd_s = 1'b0;
`endif

    // Read data multiplexer; unmapped offsets and DATA_IN read as zero
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (ar_off_s)
            REG_CTRL:   rd_data_s = {30'h0000_0000, irq_en_rd_s, 1'b0};
            REG_STATUS: rd_data_s = {29'h0000_0000, overrun_r, done_r, eng_busy_s};
            REG_HASH:   rd_data_s = eng_hash_s;
            default: begin
                for (int k = 0; k < NUM_USER_REGS; k++) begin
                    rd_data_s = rd_data_s | (scratch_r[k] & {32{user_rsel_s[k]}});
                end
            end
        endcase
    end

    // Read address handshake with registered data held until RREADY
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
        end else begin
            arready_r <= !arready_r && S_AXI_ARVALID && !rvalid_r;
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    fnv1a_byte_engine u_engine (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .load_seed (init_s),
        .start     (eng_start_s),
        .lane_mask (S_AXI_WSTRB),
        .word      (S_AXI_WDATA),
        .hash      (eng_hash_s),
        .busy      (eng_busy_s),
        .done      (eng_done_s)
    );

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = awready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_hash_axil_fnv.sv
// Table-driven register checks plus hand-written hash sequences, scored through a queue.
module tb_hash_axil_fnv;

    localparam logic [31:0] SEED = 32'h811C_9DC5;
`ifdef HASH_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h0000_0002;
`else
    localparam logic [31:0] CTRL_RB = 32'h0000_0000;
`endif

    logic        aclk, aresetn;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
`ifdef HASH_IRQ_EN
    logic        irq;
`endif

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        logic [1:0]  resp;
        string       tag;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       tag;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[22];
    int   tests = 0;
    int   fails = 0;

    hash_axil_fnv #(.C_S_AXI_ADDR_WIDTH(6), .NUM_USER_REGS(4)) dut (
`ifdef HASH_IRQ_EN
        .irq           (irq),
`endif
        .S_AXI_ACLK    (aclk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Independent FNV-1a model over the strobed lanes of a word
    function automatic logic [31:0] fnv_model(input logic [31:0] h, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] x;
        x = h;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                x = x ^ {24'h00_0000, w[8*i +: 8]};
                x = x * 32'h0100_0193;
            end
        end
        return x;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input string tag);
        bit got;
        sb_q.push_back('{1'b0, 32'h0, resp, tag});
        awaddr = addr[5:0]; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (awready && wready) got = 1'b1;
        end
        if (!got) begin
            check({tag, ".aw_timeout"}, 32'h1, 32'h0);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (bvalid) got = 1'b1;
        end
        if (!got) check({tag, ".b_timeout"}, 32'h1, 32'h0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                            input string tag);
        bit got;
        sb_q.push_back('{1'b1, data, resp, tag});
        araddr = addr[5:0];
        arvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (arready) got = 1'b1;
        end
        if (!got) begin
            check({tag, ".ar_timeout"}, 32'h1, 32'h0);
            arvalid = 1'b0;
            return;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (rvalid) got = 1'b1;
        end
        if (!got) check({tag, ".r_timeout"}, 32'h1, 32'h0);
    endtask

    // Scoreboard: pop one expectation per completed response beat
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && bvalid && bready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_b", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, ".kind"}, {31'h0, e.is_read}, 32'h0);
                check({e.tag, ".bresp"}, {30'h0, bresp}, {30'h0, e.resp});
            end
        end
        if (aresetn && rvalid && rready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_r", 32'h1, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check({e.tag, ".kind"}, {31'h0, e.is_read}, 32'h1);
                check({e.tag, ".rdata"}, rdata, e.data);
                check({e.tag, ".rresp"}, {30'h0, rresp}, {30'h0, e.resp});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0C, 32'h0,        4'h0, SEED,         2'b00, "rst_hash"};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        2'b00, "rst_status"};
        vecs[2]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        2'b00, "rst_ctrl"};
        vecs[3]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'h0,        2'b00, "rst_scr0"};
        vecs[4]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00, "scr0_full"};
        vecs[5]  = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0,        2'b00, "scr0_lane0"};
        vecs[6]  = '{1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00, "scr0_rd"};
        vecs[7]  = '{1'b1, 32'h14, 32'h12345678, 4'hC, 32'h0,        2'b00, "scr1_hi"};
        vecs[8]  = '{1'b0, 32'h14, 32'h0,        4'h0, 32'h12340000, 2'b00, "scr1_rd"};
        vecs[9]  = '{1'b1, 32'h1C, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00, "scr3_full"};
        vecs[10] = '{1'b0, 32'h1C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, "scr3_rd"};
        vecs[11] = '{1'b1, 32'h3C, 32'h1,        4'hF, 32'h0,        2'b10, "wr_unmapped_3c"};
        vecs[12] = '{1'b1, 32'h20, 32'h1,        4'hF, 32'h0,        2'b10, "wr_unmapped_20"};
        vecs[13] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h0,        2'b00, "rd_unmapped"};
        vecs[14] = '{1'b1, 32'h0C, 32'h0,        4'hF, 32'h0,        2'b10, "wr_hash_ro"};
        vecs[15] = '{1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00, "data_strb0"};
        vecs[16] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h0,        2'b00, "status_after_strb0"};
        vecs[17] = '{1'b0, 32'h0C, 32'h0,        4'h0, SEED,         2'b00, "hash_unchanged"};
        vecs[18] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'h0,        2'b00, "rd_data_in"};
        vecs[19] = '{1'b1, 32'h00, 32'h2,        4'hF, 32'h0,        2'b00, "ctrl_irq_en"};
        vecs[20] = '{1'b0, 32'h00, 32'h0,        4'h0, CTRL_RB,      2'b00, "ctrl_rb"};
        vecs[21] = '{1'b0, 32'h12, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00, "addr_low_ignored"};

        aresetn = 1'b0;
        awaddr = 6'h0; araddr = 6'h0; awprot = 3'h0; arprot = 3'h0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_handshake", {27'h0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
`ifdef HASH_IRQ_EN
        check("rst_irq", {31'h0, irq}, 32'h0);
`endif
        aresetn = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].tag);
            else            axi_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].tag);
        end

        // Single byte: one busy cycle, done already visible on the first status read
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, "a_init");
        axi_write(32'h08, 32'h00000061, 4'h1, 2'b00, "a_data");
        axi_read(32'h04, 32'h2, 2'b00, "a_status");
        axi_read(32'h0C, 32'hE40C292C, 2'b00, "a_hash");

        // "foobar" in two words, with an intermediate digest read while busy
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, "f_init");
        axi_write(32'h08, 32'h626F6F66, 4'hF, 2'b00, "f_word0");
        axi_read(32'h0C, fnv_model(SEED, 32'h00000066, 4'h1), 2'b00, "f_hash_mid");
        repeat (6) @(negedge aclk);
        axi_write(32'h08, 32'h00007261, 4'h3, 2'b00, "f_word1");
        repeat (6) @(negedge aclk);
        axi_read(32'h0C, 32'hBF9CF968, 2'b00, "f_hash");

        // Back-to-back DATA_IN: overrun, dropped data, W1C of OVERRUN
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, "o_init");
        axi_write(32'h08, 32'h11223344, 4'hF, 2'b00, "o_first");
        axi_write(32'h08, 32'h55667788, 4'hF, 2'b10, "o_second");
        repeat (6) @(negedge aclk);
        axi_read(32'h04, 32'h6, 2'b00, "o_status");
        axi_read(32'h0C, fnv_model(SEED, 32'h11223344, 4'hF), 2'b00, "o_hash");
        axi_write(32'h04, 32'h4, 4'hF, 2'b00, "o_w1c");
        axi_read(32'h04, 32'h2, 2'b00, "o_status_clr");

        // BUSY observed mid-run, then INIT aborts and reloads the seed
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, "b_init");
        axi_write(32'h08, 32'hA5A5A5A5, 4'hF, 2'b00, "b_data");
        axi_read(32'h04, 32'h1, 2'b00, "b_busy");
        axi_write(32'h00, 32'h1, 4'hF, 2'b00, "b_abort");
        repeat (6) @(negedge aclk);
        axi_read(32'h04, 32'h0, 2'b00, "b_status");
        axi_read(32'h0C, SEED, 2'b00, "b_hash_seed");

        // Reset asserted mid-hash with a response pending
        axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 2'b00, "r_data");
        #2 aresetn = 1'b0;
        #1;
        check("r_async_outs", {27'h0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        axi_read(32'h0C, SEED, 2'b00, "r_hash");
        axi_read(32'h04, 32'h0, 2'b00, "r_status");
        axi_read(32'h10, 32'h0, 2'b00, "r_scr0");

`ifdef HASH_IRQ_EN
        axi_write(32'h00, 32'h3, 4'hF, 2'b00, "i_ctrl");
        axi_write(32'h08, 32'h00000061, 4'h1, 2'b00, "i_data");
        repeat (4) @(negedge aclk);
        check("i_irq_set", {31'h0, irq}, 32'h1);
        axi_write(32'h04, 32'h2, 4'hF, 2'b00, "i_w1c");
        check("i_irq_hold", {31'h0, irq}, 32'h1);
        @(negedge aclk);
        check("i_irq_clr", {31'h0, irq}, 32'h0);
        axi_read(32'h04, 32'h0, 2'b00, "i_status");
`endif

        repeat (4) @(negedge aclk);
        check("sb_drain", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hash_axil_fnv.md
# hash_axil_fnv

AXI4-Lite slave that generalises the four-register hash peripheral into a parametrised register bank with a working FNV-1a 32-bit hash engine. Software writes message bytes through a data register, polls or takes an interrupt on completion, and reads the digest back. The block sits behind the block-design AXI interconnect as a memory-mapped peripheral in the hash IP.

## Interface
Parameters:
- `C_S_AXI_ADDR_WIDTH`, 6: byte address width. Require `4 + NUM_USER_REGS <= 2**(C_S_AXI_ADDR_WIDTH-2)`.
- `NUM_USER_REGS`, 4: number of read/write scratch registers, range 1..8.

Data width is fixed at 32; `WSTRB` is 4 bits.

Ports:
- `S_AXI_ACLK` in 1: the single clock.
- `S_AXI_ARESETN` in 1: reset, asynchronous and active-low.
- `S_AXI_AWADDR` in ADDR_WIDTH, `S_AXI_AWPROT` in 3, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARADDR` in ADDR_WIDTH, `S_AXI_ARPROT` in 3, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `irq` out 1: completion interrupt. Present only with `HASH_IRQ_EN`.

## Operation
Register map (word offsets; `ADDR[1:0]` ignored):
- 0x00 CTRL:
  - bit0 INIT, write-1 self-clearing pulse. Sets HASH to 0x811C9DC5 and clears DONE/OVERRUN.
  - bit1 IRQ_EN, R/W.
- 0x04 STATUS:
  - bit0 BUSY, read-only.
  - bit1 DONE, sticky, write-1-to-clear.
  - bit2 OVERRUN, sticky, write-1-to-clear.
- 0x08 DATA_IN: write-only; reads return 0. A write queues the byte lanes whose `WSTRB` bit is set, ascending lane order.
- 0x0C HASH: read-only digest.
- 0x10+4k: scratch register k, R/W with byte strobes.

Hash engine:
- Processes 1 byte/cycle: `h = (h ^ byte) * 32'h01000193`, taken mod 2^32.
- States: IDLE, RUN.
  - IDLE→RUN on an accepted DATA_IN write with a non-zero strobe.
  - RUN→IDLE after the last strobed lane is processed; DONE is set on that cycle.
- `WSTRB = 0` to DATA_IN: response OKAY, no state change.
- DATA_IN write while BUSY: data dropped, OVERRUN set, BRESP = SLVERR (2'b10).
- INIT while BUSY: aborts RUN, goes to IDLE, loads the seed.
- Writes to unmapped or read-only offsets: SLVERR, no state change.
- Reads of unmapped offsets: RDATA 0, RRESP OKAY.

## Timing
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, HASH 0x811C9DC5, CTRL 0, STATUS 0, scratch 0, `irq` 0. Reset is honoured mid-burst and mid-hash; the engine returns to IDLE immediately.
- Write handshake:
  - AWREADY and WREADY pulse together for one cycle when AWVALID, WVALID are both high and BVALID is low.
  - BVALID rises the next cycle and is held until BREADY.
  - Only one outstanding write.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RVALID and RDATA are registered the next cycle and held until RREADY.
- Hash latency: BUSY is visible the cycle after the write handshake and stays high N cycles (N = set strobe bits). HASH and DONE update on the same edge.
- Simultaneous STATUS W1C of DONE and hash completion: completion wins, so DONE stays set.
- HASH read while BUSY returns the intermediate value.

## Configuration
- `HASH_IRQ_EN` defined:
  - `irq` port exists, registered as `DONE & IRQ_EN`.
  - It deasserts the cycle after DONE is cleared.
- Undefined:
  - No `irq` port.
  - CTRL bit1 is writable-ignored and reads 0.

## Structure
- Package `hash_axil_pkg` holds:
  - register offset localparams;
  - FNV seed 0x811C9DC5 and prime 0x01000193;
  - response codes OKAY/SLVERR;
  - the engine state enum.
- Sub-module `fnv1a_byte_engine`: takes a byte-lane mask and a word, plus seed-load and abort; outputs hash, busy and done pulse. The AXI decode stays in the top level.

## Test plan
- Reset, then read 0x0C → 0x811C9DC5, OKAY; read 0x04 → 0.
- INIT; write DATA_IN 0x00000061, WSTRB 4'b0001 → BUSY for 1 cycle, HASH = 0xE40C292C, STATUS = 0x2.
- INIT; write 0x626F6F66 (WSTRB 1111), wait; write 0x00007261 (WSTRB 0011) → HASH = 0xBF9CF968 ("foobar").
- Write DATA_IN twice back-to-back with full strobes → second BRESP = SLVERR, OVERRUN = 1; write 0x4 to STATUS → OVERRUN = 0.
- Scratch 0 at 0x10: write 0xDEADBEEF, then 0x000000AA with WSTRB 0001 → read 0xDEADBEAA; write to 0x3C with NUM_USER_REGS = 4 → SLVERR.
- With `HASH_IRQ_EN`: set IRQ_EN and hash one byte → `irq` = 1; write 0x2 to STATUS → `irq` = 0 the next cycle.
